// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the receive-side blocks.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_RX_DEPTH   = 8;
  localparam int ERR_CNT_W       = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver-to-buffer and buffer-to-consumer signal bundle.
interface uart_rx_buffer_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_RX_DEPTH
);

  logic [DATA_WIDTH-1:0]    P_DATA;
  logic                     data_valid;
  logic                     frame_err;
  logic                     rd_ready;
  logic                     clr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic [ERR_CNT_W-1:0]     err_cnt;

  // Receiver/consumer side drives the inputs and observes the buffer state.
  modport master (
    output P_DATA, data_valid, frame_err, rd_ready, clr,
    input  rd_data, rd_valid, count, overflow, err_cnt
  );

  // Buffer side.
  modport slave (
    input  P_DATA, data_valid, frame_err, rd_ready, clr,
    output rd_data, rd_valid, count, overflow, err_cnt
  );

endinterface

// File: rtl/uart_rx_buf_mem.sv
// Storage array for the RX buffer: one write port, asynchronous read, no reset.
module uart_rx_buf_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are only meaningful for occupied slots.
  always_ff @(posedge CLK) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_buffer.sv
// First-word-fall-through buffer between the UART deserializer and its consumer,
// with sticky overflow and a saturating frame-error counter.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_RX_DEPTH
) (
  input  logic             CLK,
  input  logic             RST,
  uart_rx_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic push, pop, full, wr_en, drop;

  // A word flagged both good and bad is treated as an error, never stored.
  assign push  = bus.data_valid & ~bus.frame_err;
  assign pop   = (count_q != '0) & bus.rd_ready;
  assign full  = (count_q == PW'(DEPTH));
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // Next-state for pointers, occupancy and status flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q;
    overflow_d = overflow_q;
    err_cnt_d  = err_cnt_q;

    if (wr_en && !pop)      count_d = count_q + PW'(1);
    else if (pop && !wr_en) count_d = count_q - PW'(1);

    // New events beat a coincident clear so nothing is lost.
    if (drop)         overflow_d = 1'b1;
    else if (bus.clr) overflow_d = 1'b0;

    if (bus.frame_err) err_cnt_d = bus.clr ? ERR_CNT_W'(1) : sat_inc(err_cnt_q);
    else if (bus.clr)  err_cnt_d = '0;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  uart_rx_buf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .CLK     (CLK),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.P_DATA),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (bus.rd_data)
  );

  assign bus.rd_valid = (count_q != '0);
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule
